// File: rtl/mem_pkg.sv
// Shared types and defaults for the parameterised data memory.
package mem_pkg;

    typedef enum logic [1:0] {
        LIMPA    = 2'd0,
        OCIOSO   = 2'd1,
        AGUARDA  = 2'd2,
        RESPOSTA = 2'd3
    } estado_t;

    localparam int LARG_DADO_PADRAO   = 32;
    localparam int LARG_END_PADRAO    = 8;
    localparam int PROF_PADRAO        = 256;
    localparam int ESPERA_PADRAO      = 1;
    localparam int LIMPA_RESET_PADRAO = 1;
    localparam int ESPERA_MAX         = 7;

endpackage

// File: rtl/mem_dados_array.sv
// Word storage: byte-enabled synchronous write, combinational read.
// Addresses at or beyond PROF never write and read back as zero.
module mem_dados_array #(
    parameter int LARG_DADO = 32,
    parameter int LARG_END  = 8,
    parameter int PROF      = 256
) (
    input  logic                   clk,
    input  logic [LARG_DADO/8-1:0] hab_bytes,
    input  logic [LARG_END-1:0]    end_escrita,
    input  logic [LARG_DADO-1:0]   dado_escrita,
    input  logic [LARG_END-1:0]    end_leitura,
    output logic [LARG_DADO-1:0]   dado_leitura
);

    localparam int                NB       = LARG_DADO / 8;
    localparam logic [LARG_END:0] PROF_LIM = (LARG_END + 1)'(PROF);

    logic [LARG_DADO-1:0] mem [PROF];
    logic                 esc_ok;
    logic                 lei_ok;

    assign esc_ok = ({1'b0, end_escrita} < PROF_LIM);
    assign lei_ok = ({1'b0, end_leitura} < PROF_LIM);

    // byte-lane write; the array has no reset on purpose
    always_ff @(posedge clk) begin
        if (esc_ok) begin
            for (int b = 0; b < NB; b++) begin
                if (hab_bytes[b]) begin
                    mem[end_escrita][8*b +: 8] <= dado_escrita[8*b +: 8];
                end
            end
        end
    end

    // combinational read with out-of-range forced to zero
    always_comb begin
        dado_leitura = '0;
        if (lei_ok) begin
            dado_leitura = mem[end_leitura];
        end
    end

endmodule

// File: rtl/mem_dados_param.sv
// Request/ready data memory with read wait states and optional zero-fill
// after reset.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   LIMPA    | zero-filling addresses 0..PROF-1, one per cycle, busy
//   OCIOSO   | idle, ready for a read or write request
//   AGUARDA  | read accepted, counting down the wait states
//   RESPOSTA | read data valid for one cycle, ready for the next request
module mem_dados_param
    import mem_pkg::*;
#(
    parameter int LARG_DADO   = LARG_DADO_PADRAO,
    parameter int LARG_END    = LARG_END_PADRAO,
    parameter int PROF        = PROF_PADRAO,
    parameter int ESPERA      = ESPERA_PADRAO,
    parameter int LIMPA_RESET = LIMPA_RESET_PADRAO
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic                   Req,
    input  logic                   EscritaReq,
    input  logic [LARG_END-1:0]    Endereco,
    input  logic [LARG_DADO-1:0]   DadoEscrita,
    input  logic [LARG_DADO/8-1:0] BytesHab,
    output logic                   Pronto,
    output logic                   DadoValido,
    output logic [LARG_DADO-1:0]   DadoLido,
    output logic                   ErroEnd,
    output logic                   Ocupado
);

    if ((LARG_DADO % 8) != 0 || LARG_DADO < 8) begin : g_err_larg_dado
        $error("mem_dados_param: LARG_DADO must be a non-zero multiple of 8");
    end
    if (PROF < 1 || PROF > (1 << LARG_END)) begin : g_err_prof
        $error("mem_dados_param: PROF must be in 1..2**LARG_END");
    end
    if (ESPERA < 0 || ESPERA > ESPERA_MAX) begin : g_err_espera
        $error("mem_dados_param: ESPERA must be in 0..7");
    end

    localparam int                NB            = LARG_DADO / 8;
    localparam logic [LARG_END:0] PROF_LIM      = (LARG_END + 1)'(PROF);
    localparam logic [LARG_END:0] ULT_LIMPA     = (LARG_END + 1)'(PROF - 1);
    localparam logic [LARG_END:0] UM_LIMPA      = (LARG_END + 1)'(1);
    localparam logic [2:0]        ESPERA_CARGA  = (ESPERA > 0) ? 3'(ESPERA - 1) : 3'd0;
    localparam estado_t           ESTADO_RESET  = (LIMPA_RESET != 0) ? LIMPA : OCIOSO;
    localparam logic              OCUPADO_RESET = (LIMPA_RESET != 0);

    estado_t              estado_q,     estado_d;
    logic [LARG_END:0]    limpa_cnt_q,  limpa_cnt_d;
    logic [2:0]           espera_cnt_q, espera_cnt_d;
    logic [LARG_END-1:0]  end_q,        end_d;
    logic                 pronto_q,     pronto_d;
    logic                 valido_q,     valido_d;
    logic [LARG_DADO-1:0] lido_q,       lido_d;
    logic                 erro_q,       erro_d;
    logic                 ocupado_q,    ocupado_d;

    logic                 aceita;
    logic                 fora_req;
    logic                 fora_cap;
    logic [NB-1:0]        hab_esc;
    logic [LARG_END-1:0]  end_esc;
    logic [LARG_DADO-1:0] dado_esc;
    logic [LARG_END-1:0]  end_lei;
    logic [LARG_DADO-1:0] dado_lei;

    // pronto_q is high exactly in OCIOSO and RESPOSTA, so it gates the handshake
    assign aceita   = Req && pronto_q;
    assign fora_req = ({1'b0, Endereco} >= PROF_LIM);
    assign fora_cap = ({1'b0, end_q} >= PROF_LIM);
    // waiting reads use the captured address; a zero-wait read uses the live one
    assign end_lei  = (estado_q == AGUARDA) ? end_q : Endereco;

    mem_dados_array #(
        .LARG_DADO (LARG_DADO),
        .LARG_END  (LARG_END),
        .PROF      (PROF)
    ) u_array (
        .clk          (CLK),
        .hab_bytes    (hab_esc),
        .end_escrita  (end_esc),
        .dado_escrita (dado_esc),
        .end_leitura  (end_lei),
        .dado_leitura (dado_lei)
    );

    // next-state, counters, storage write port and next registered outputs
    always_comb begin
        estado_d     = estado_q;
        limpa_cnt_d  = limpa_cnt_q;
        espera_cnt_d = espera_cnt_q;
        end_d        = end_q;
        valido_d     = 1'b0;
        lido_d       = '0;
        erro_d       = 1'b0;
        hab_esc      = '0;
        end_esc      = Endereco;
        dado_esc     = DadoEscrita;

        case (estado_q)
            LIMPA: begin
                hab_esc     = '1;
                end_esc     = limpa_cnt_q[LARG_END-1:0];
                dado_esc    = '0;
                limpa_cnt_d = limpa_cnt_q + UM_LIMPA;
                if (limpa_cnt_q == ULT_LIMPA) begin
                    estado_d = OCIOSO;
                end
            end
            AGUARDA: begin
                if (espera_cnt_q == 3'd0) begin
                    estado_d = RESPOSTA;
                    valido_d = 1'b1;
                    lido_d   = dado_lei;
                    erro_d   = fora_cap;
                end else begin
                    espera_cnt_d = espera_cnt_q - 3'd1;
                end
            end
            default: begin
                estado_d = OCIOSO;
                if (aceita) begin
                    if (EscritaReq) begin
                        erro_d = fora_req;
                        if (!fora_req) begin
                            hab_esc = BytesHab;
                        end
                    end else begin
                        end_d = Endereco;
                        if (ESPERA == 0) begin
                            estado_d = RESPOSTA;
                            valido_d = 1'b1;
                            lido_d   = dado_lei;
                            erro_d   = fora_req;
                        end else begin
                            estado_d     = AGUARDA;
                            espera_cnt_d = ESPERA_CARGA;
                        end
                    end
                end
            end
        endcase

        pronto_d  = (estado_d == OCIOSO) || (estado_d == RESPOSTA);
        ocupado_d = (estado_d == LIMPA);
    end

    // FSM state, counters and registered outputs
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            estado_q     <= ESTADO_RESET;
            limpa_cnt_q  <= '0;
            espera_cnt_q <= 3'd0;
            end_q        <= '0;
            pronto_q     <= 1'b0;
            valido_q     <= 1'b0;
            lido_q       <= '0;
            erro_q       <= 1'b0;
            ocupado_q    <= OCUPADO_RESET;
        end else begin
            estado_q     <= estado_d;
            limpa_cnt_q  <= limpa_cnt_d;
            espera_cnt_q <= espera_cnt_d;
            end_q        <= end_d;
            pronto_q     <= pronto_d;
            valido_q     <= valido_d;
            lido_q       <= lido_d;
            erro_q       <= erro_d;
            ocupado_q    <= ocupado_d;
        end
    end

    assign Pronto     = pronto_q;
    assign DadoValido = valido_q;
    assign DadoLido   = lido_q;
    assign ErroEnd    = erro_q;
    assign Ocupado    = ocupado_q;

endmodule

// File: tb/tb_mem_dados_param.sv
// Bench for mem_dados_param: two instances (PROF=256/ESPERA=3 and
// PROF=200/ESPERA=0), table-driven accesses, scoreboard of read responses.
module tb_mem_dados_param;

    localparam int ESP0 = 3;
    localparam int ESP1 = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        int          d;
        bit          wr;
        logic [7:0]  a;
        logic [31:0] dat;
        logic [3:0]  be;
        logic [31:0] exp_d;
        bit          exp_e;
    } vec_t;

    logic        CLK = 1'b0;
    logic [1:0]  rst_n = 2'b11;
    logic [1:0]  req = 2'b00;
    logic [1:0]  wr = 2'b00;
    logic [1:0]  pronto;
    logic [1:0]  dval;
    logic [1:0]  erro;
    logic [1:0]  ocup;
    logic [7:0]  addr [2];
    logic [31:0] wdat [2];
    logic [31:0] rdat [2];
    logic [3:0]  be   [2];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t w0[$];
    exp_t w1[$];
    vec_t tv[$];

    mem_dados_param #(
        .LARG_DADO(32), .LARG_END(8), .PROF(256), .ESPERA(ESP0), .LIMPA_RESET(1)
    ) u_dut0 (
        .CLK(CLK), .RSTn(rst_n[0]), .Req(req[0]), .EscritaReq(wr[0]),
        .Endereco(addr[0]), .DadoEscrita(wdat[0]), .BytesHab(be[0]),
        .Pronto(pronto[0]), .DadoValido(dval[0]), .DadoLido(rdat[0]),
        .ErroEnd(erro[0]), .Ocupado(ocup[0])
    );

    mem_dados_param #(
        .LARG_DADO(32), .LARG_END(8), .PROF(200), .ESPERA(ESP1), .LIMPA_RESET(1)
    ) u_dut1 (
        .CLK(CLK), .RSTn(rst_n[1]), .Req(req[1]), .EscritaReq(wr[1]),
        .Endereco(addr[1]), .DadoEscrita(wdat[1]), .BytesHab(be[1]),
        .Pronto(pronto[1]), .DadoValido(dval[1]), .DadoLido(rdat[1]),
        .ErroEnd(erro[1]), .Ocupado(ocup[1])
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic mon(input int d);
        exp_t e;
        int   n;
        if (rst_n[d] == 1'b0) begin
            if (d == 0) begin q0.delete(); w0.delete(); end
            else        begin q1.delete(); w1.delete(); end
            return;
        end
        n = (d == 0) ? q0.size() : q1.size();
        if (dval[d]) begin
            chk($sformatf("resp_expected%0d", d), {31'd0, n > 0}, 1);
            if (n > 0) begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("rd_cycle%0d", d), cyc, e.cyc);
                chk($sformatf("rd_data%0d", d), rdat[d], e.data);
                chk($sformatf("rd_err%0d", d), {31'd0, erro[d]}, {31'd0, e.err});
            end
        end else begin
            chk($sformatf("lido_idle%0d", d), rdat[d], 0);
        end
        n = (d == 0) ? w0.size() : w1.size();
        if (n > 0) begin
            e = (d == 0) ? w0[0] : w1[0];
            if (e.cyc == cyc) begin
                chk($sformatf("wr_err%0d", d), {31'd0, erro[d]}, {31'd0, e.err});
                if (d == 0) void'(w0.pop_front()); else void'(w1.pop_front());
            end
        end
    endtask

    always @(negedge CLK) begin
        mon(0);
        mon(1);
    end

    // waits for Pronto, then presents a request that the next rising edge accepts
    task automatic drive(input int d, input bit w, input logic [7:0] a, input logic [31:0] dat,
                         input logic [3:0] b, input logic [31:0] exp_d, input bit exp_e,
                         input bit track);
        int   n;
        exp_t e;
        n = 0;
        @(negedge CLK);
        while (pronto[d] !== 1'b1 && n < 600) begin
            @(negedge CLK);
            n++;
        end
        chk($sformatf("pronto_wait%0d", d), {31'd0, pronto[d]}, 1);
        if (pronto[d] !== 1'b1) return;
        req[d]  = 1'b1;
        wr[d]   = w;
        addr[d] = a;
        wdat[d] = dat;
        be[d]   = b;
        e.data  = exp_d;
        e.err   = exp_e;
        if (w) begin
            e.cyc = cyc + 1;
            if (d == 0) w0.push_back(e); else w1.push_back(e);
        end else if (track) begin
            e.cyc = cyc + ((d == 0) ? ESP0 : ESP1) + 1;
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic idle(input int d);
        @(negedge CLK);
        req[d] = 1'b0;
    endtask

    // releases reset at a falling edge and counts busy cycles until ready
    task automatic measure_fill(input int d, output int n, output bit p_during, output bit p_after);
        rst_n[d] = 1'b1;
        n = 0;
        p_during = 1'b0;
        for (int j = 0; j < 400; j++) begin
            if (!ocup[d]) break;
            if (pronto[d]) p_during = 1'b1;
            n++;
            @(negedge CLK);
        end
        p_after = pronto[d];
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit pd;
        bit pa;
        int seen;

        for (int d = 0; d < 2; d++) begin
            addr[d] = '0; wdat[d] = '0; be[d] = '0;
        end
        #2 rst_n = 2'b00;

        @(negedge CLK);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_pronto%0d", d), {31'd0, pronto[d]}, 0);
            chk($sformatf("rst_valido%0d", d), {31'd0, dval[d]}, 0);
            chk($sformatf("rst_lido%0d", d), rdat[d], 0);
            chk($sformatf("rst_erro%0d", d), {31'd0, erro[d]}, 0);
            chk($sformatf("rst_ocupado%0d", d), {31'd0, ocup[d]}, 1);
        end

        @(negedge CLK);
        measure_fill(0, n, pd, pa);
        chk("fill_len0", n, 256);
        chk("fill_pronto_low0", {31'd0, pd}, 0);
        chk("fill_pronto_after0", {31'd0, pa}, 1);
        measure_fill(1, n, pd, pa);
        chk("fill_len1", n, 200);
        chk("fill_pronto_low1", {31'd0, pd}, 0);
        chk("fill_pronto_after1", {31'd0, pa}, 1);

        tv.push_back('{0, 1'b0, 8'h7F, 32'h0,        4'h0, 32'h00000000, 1'b0});
        tv.push_back('{0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0});
        tv.push_back('{0, 1'b1, 8'h10, 32'h000000AA, 4'h1, 32'h0,        1'b0});
        tv.push_back('{0, 1'b0, 8'h10, 32'h0,        4'h0, 32'hDEADBEAA, 1'b0});
        tv.push_back('{0, 1'b1, 8'h20, 32'h12345678, 4'hF, 32'h0,        1'b0});
        tv.push_back('{0, 1'b1, 8'h20, 32'hAABBCCDD, 4'hA, 32'h0,        1'b0});
        tv.push_back('{0, 1'b0, 8'h20, 32'h0,        4'h0, 32'hAA34CC78, 1'b0});
        tv.push_back('{0, 1'b1, 8'hFF, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0});
        tv.push_back('{0, 1'b0, 8'hFF, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0});
        tv.push_back('{0, 1'b1, 8'h30, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0});
        tv.push_back('{0, 1'b0, 8'h30, 32'h0,        4'h0, 32'h00000000, 1'b0});
        tv.push_back('{1, 1'b1, 8'hF0, 32'h11111111, 4'hF, 32'h0,        1'b1});
        tv.push_back('{1, 1'b0, 8'hF0, 32'h0,        4'h0, 32'h00000000, 1'b1});
        tv.push_back('{1, 1'b0, 8'h00, 32'h0,        4'h0, 32'h00000000, 1'b0});
        tv.push_back('{1, 1'b0, 8'h28, 32'h0,        4'h0, 32'h00000000, 1'b0});
        tv.push_back('{1, 1'b1, 8'hC7, 32'h55AA55AA, 4'hF, 32'h0,        1'b0});
        tv.push_back('{1, 1'b0, 8'hC7, 32'h0,        4'h0, 32'h55AA55AA, 1'b0});
        tv.push_back('{1, 1'b1, 8'hC8, 32'h77777777, 4'hF, 32'h0,        1'b1});
        tv.push_back('{1, 1'b0, 8'hC8, 32'h0,        4'h0, 32'h00000000, 1'b1});
        tv.push_back('{1, 1'b1, 8'h01, 32'h00000011, 4'hF, 32'h0,        1'b0});
        tv.push_back('{1, 1'b1, 8'h02, 32'h00000022, 4'hF, 32'h0,        1'b0});

        foreach (tv[i]) begin
            drive(tv[i].d, tv[i].wr, tv[i].a, tv[i].dat, tv[i].be, tv[i].exp_d, tv[i].exp_e, 1'b1);
            idle(tv[i].d);
        end

        // wait-state timing with ESPERA=3: ready low for three cycles, response on the fourth
        drive(0, 1'b0, 8'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 1'b1);
        for (int j = 1; j <= 3; j++) begin
            @(negedge CLK);
            if (j == 1) req[0] = 1'b0;
            chk($sformatf("wait_pronto_c%0d", j), {31'd0, pronto[0]}, 0);
            chk($sformatf("wait_valido_c%0d", j), {31'd0, dval[0]}, 0);
        end
        @(negedge CLK);
        chk("wait_valido_c4", {31'd0, dval[0]}, 1);

        // back-to-back zero-wait reads, second issued while the first responds
        drive(1, 1'b0, 8'h01, 32'h0, 4'h0, 32'h00000011, 1'b0, 1'b1);
        drive(1, 1'b0, 8'h02, 32'h0, 4'h0, 32'h00000022, 1'b0, 1'b1);
        chk("b2b_first_valid", {31'd0, dval[1]}, 1);
        chk("b2b_first_data", rdat[1], 32'h00000011);
        idle(1);
        chk("b2b_second_valid", {31'd0, dval[1]}, 1);
        chk("b2b_second_data", rdat[1], 32'h00000022);

        // back-to-back reads with wait states: responses four cycles apart
        drive(0, 1'b0, 8'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 1'b1);
        drive(0, 1'b0, 8'h20, 32'h0, 4'h0, 32'hAA34CC78, 1'b0, 1'b1);
        idle(0);

        // reset in the second wait cycle aborts the read and restarts the fill
        drive(0, 1'b0, 8'h10, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        idle(0);
        @(negedge CLK);
        chk("abort_in_wait_pronto", {31'd0, pronto[0]}, 0);
        rst_n[0] = 1'b0;
        #1;
        chk("abort_ocupado", {31'd0, ocup[0]}, 1);
        chk("abort_pronto", {31'd0, pronto[0]}, 0);
        chk("abort_valido", {31'd0, dval[0]}, 0);
        seen = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge CLK);
            seen += int'(dval[0]);
        end
        chk("abort_no_valid", seen, 0);
        measure_fill(0, n, pd, pa);
        chk("refill_len0", n, 256);
        chk("refill_pronto_after0", {31'd0, pa}, 1);
        drive(0, 1'b0, 8'h10, 32'h0, 4'h0, 32'h00000000, 1'b0, 1'b1);
        idle(0);

        repeat (10) @(negedge CLK);
        chk("pending_reads0", q0.size(), 0);
        chk("pending_reads1", q1.size(), 0);
        chk("pending_writes", w0.size() + w1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
